// File: rtl/fetch_sequencer.sv
// fetch_sequencer: SAP-2 instruction fetch front-end.
// Owns the PC, drives it onto the shared bus, and strobes the memory block
// (MAR load, RAM read) to collect the opcode plus 0/1/2 operand bytes.
// The assembled instruction is handed to execute through instr_valid/ack.
// Optional build macro FETCH_PERF_EN adds instr_count/stall_count outputs.
//
// state  | meaning
// IDLE   | waiting for start; pc_load accepted here
// A_OP   | PC on bus, load MAR for opcode, pc++
// R_OP   | read opcode byte into MDR[7:0]
// C_OP   | capture opcode, decode length
// A_B1   | PC on bus, load MAR for first operand byte, pc++
// R_B1   | read first operand byte (high half for 3-byte, low for 2-byte)
// A_B2   | PC on bus, load MAR for second operand byte, pc++
// R_B2   | read second operand byte into MDR[7:0]
// C_OPR  | capture operand
// VALID  | instruction presented until ack

module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   input  logic        pc_load,
   input  logic [15:0] pc_in,
   input  logic [15:0] mem_out,
   output logic [15:0] bus_out,
   output logic        bus_oe,
   output logic        mar_loadh,
   output logic        mar_loadl,
   output logic        ram_enh,
   output logic        ram_enl,
   output logic [15:0] pc,
   output logic [7:0]  instr,
   output logic [15:0] operand,
   output logic        instr_valid,
   input  logic        ack,
   output logic        busy
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] instr_count,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_A_OP, S_R_OP, S_C_OP, S_A_B1,
      S_R_B1, S_A_B2, S_R_B2, S_C_OPR, S_VALID
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  instr_q, instr_d;
   logic [15:0] operand_q, operand_d;
   logic        halt_q, halt_d;

   // State and datapath registers, async active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 8'h00;
         operand_q <= 16'h0000;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         operand_q <= operand_d;
         halt_q    <= halt_d;
      end
   end

   // Next state, PC update, opcode/operand capture and halt flag
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      operand_d = operand_q;
      halt_d    = halt_q;
      if (state_q != S_IDLE && halt_req)
         halt_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (pc_load)
               pc_d = pc_in;
            if (start)
               state_d = S_A_OP;
         end
         S_A_OP: begin
            pc_d    = pc_q + 16'h0001;
            state_d = S_R_OP;
         end
         S_R_OP:
            state_d = S_C_OP;
         S_C_OP: begin
            instr_d   = mem_out[7:0];
            operand_d = 16'h0000;
            state_d   = (mem_out[7:6] == 2'b00) ? S_VALID : S_A_B1;
         end
         S_A_B1: begin
            pc_d    = pc_q + 16'h0001;
            state_d = S_R_B1;
         end
         S_R_B1:
            state_d = instr_q[7] ? S_A_B2 : S_C_OPR;
         S_A_B2: begin
            pc_d    = pc_q + 16'h0001;
            state_d = S_R_B2;
         end
         S_R_B2:
            state_d = S_C_OPR;
         S_C_OPR: begin
            operand_d = instr_q[7] ? mem_out : {8'h00, mem_out[7:0]};
            state_d   = S_VALID;
         end
         S_VALID: begin
            if (ack) begin
               if (pc_load)
                  pc_d = pc_in;
               if (halt_q) begin
                  state_d = S_IDLE;
                  halt_d  = 1'b0;
               end else begin
                  state_d = S_A_OP;
               end
            end
         end
         default:
            state_d = S_IDLE;
      endcase
   end

   // Strobes and status decode purely from state so reset clears them at once
   always_comb begin
      bus_oe      = 1'b0;
      mar_loadh   = 1'b0;
      mar_loadl   = 1'b0;
      ram_enh     = 1'b0;
      ram_enl     = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         S_A_OP, S_A_B1, S_A_B2: begin
            bus_oe    = 1'b1;
            mar_loadh = 1'b1;
            mar_loadl = 1'b1;
         end
         S_R_OP, S_R_B2:
            ram_enl = 1'b1;
         S_R_B1: begin
            ram_enh = instr_q[7];
            ram_enl = ~instr_q[7];
         end
         S_VALID:
            instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus_out = pc_q;
   assign pc      = pc_q;
   assign instr   = instr_q;
   assign operand = operand_q;
   assign busy    = (state_q != S_IDLE);

`ifdef FETCH_PERF_EN
   logic [15:0] instr_count_q, instr_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   // Performance counters, both wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count_q <= 16'h0000;
         stall_count_q <= 16'h0000;
      end else begin
         instr_count_q <= instr_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Count accepted instructions and VALID cycles spent waiting for ack
   always_comb begin
      instr_count_d = instr_count_q;
      stall_count_d = stall_count_q;
      if (state_q == S_VALID) begin
         if (ack)
            instr_count_d = instr_count_q + 16'h0001;
         else
            stall_count_d = stall_count_q + 16'h0001;
      end
   end

   assign instr_count = instr_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a small MAR/MDR memory model and a
// scoreboard of expected instructions.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_in = 16'h0000;
   logic [15:0] mem_out;
   logic [15:0] bus_out;
   logic        bus_oe, mar_loadh, mar_loadl, ram_enh, ram_enl;
   logic [15:0] pc;
   logic [7:0]  instr;
   logic [15:0] operand;
   logic        instr_valid;
   logic        ack = 1'b0;
   logic        busy;
`ifdef FETCH_PERF_EN
   logic [15:0] instr_count, stall_count;
`endif

   fetch_sequencer #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .pc_load(pc_load), .pc_in(pc_in), .mem_out(mem_out),
      .bus_out(bus_out), .bus_oe(bus_oe),
      .mar_loadh(mar_loadh), .mar_loadl(mar_loadl),
      .ram_enh(ram_enh), .ram_enl(ram_enl),
      .pc(pc), .instr(instr), .operand(operand),
      .instr_valid(instr_valid), .ack(ack), .busy(busy)
`ifdef FETCH_PERF_EN
      , .instr_count(instr_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // memory block model: MAR loads from bus, RAM reads fill MDR halves
   logic [7:0]  mem [0:255];
   logic [15:0] mar, mdr;
   assign mem_out = mdr;
   always @(posedge clk) begin
      if (mar_loadh) mar[15:8] <= bus_out[15:8];
      if (mar_loadl) mar[7:0]  <= bus_out[7:0];
      if (ram_enh)   mdr[15:8] <= mem[mar[7:0]];
      if (ram_enl)   mdr[7:0]  <= mem[mar[7:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor
   int mar_cnt = 0, enl_cnt = 0, enh_cnt = 0, viol = 0, idle_cnt = 0;
   logic [15:0] bus_hist [0:255];
   always @(negedge clk) begin
      if (mar_loadh) begin
         bus_hist[mar_cnt[7:0]] <= bus_out;
         mar_cnt <= mar_cnt + 1;
      end
      if (ram_enl) enl_cnt <= enl_cnt + 1;
      if (ram_enh) enh_cnt <= enh_cnt + 1;
      if (((mar_loadh | mar_loadl) && (ram_enh | ram_enl)) ||
          (mar_loadh != mar_loadl) || (ram_enh && ram_enl))
         viol <= viol + 1;
      if (!busy) idle_cnt <= idle_cnt + 1;
   end

   typedef struct {
      logic [7:0]  instr;
      logic [15:0] operand;
      logic [15:0] pc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] i, input logic [15:0] o,
                           input logic [15:0] p, input int l);
      exp_t e;
      e.instr = i; e.operand = o; e.pc = p; e.lat = l;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input string tag, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            at = cyc;
            return;
         end
      end
      chk({tag, " valid_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic pop_check(input string tag, input int lat);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, " sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, " latency"}, lat, e.lat);
      chk({tag, " instr"}, {24'h0, instr}, {24'h0, e.instr});
      chk({tag, " operand"}, {16'h0, operand}, {16'h0, e.operand});
      chk({tag, " pc"}, {16'h0, pc}, {16'h0, e.pc});
   endtask

   task automatic start_fetch(input bit do_load, input logic [15:0] tgt, output int e0);
      @(negedge clk);
      start = 1'b1; pc_load = do_load; pc_in = tgt;
      @(negedge clk);
      e0 = cyc;
      start = 1'b0; pc_load = 1'b0;
   endtask

   // single fetch with halt pulsed early, ack, expect return to IDLE
   task automatic fetch_one(input string tag, input bit do_load, input logic [15:0] tgt);
      int e0, v;
      start_fetch(do_load, tgt, e0);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      wait_valid(tag, v);
      pop_check(tag, v - e0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({tag, " idle_after_ack"}, {31'h0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   initial begin
      int s_mar, s_enl, s_enh, s_idle, e0, v1, v2, a0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // reset state
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst pc", {16'h0, pc}, 32'h0000);
      chk("rst instr", {24'h0, instr}, 32'h0);
      chk("rst operand", {16'h0, operand}, 32'h0);
      chk("rst outs", {26'h0, busy, instr_valid, bus_oe, mar_loadh, ram_enh, ram_enl}, 32'h0);
      rst = 1'b0;

      // 1: one-byte instruction
      mem[0] = 8'h00;
      s_mar = mar_cnt; s_enl = enl_cnt; s_enh = enh_cnt;
      push_exp(8'h00, 16'h0000, 16'h0001, 3);
      fetch_one("t1", 1'b0, 16'h0000);
      chk("t1 mar_pulses", mar_cnt - s_mar, 1);
      chk("t1 enl_pulses", enl_cnt - s_enl, 1);
      chk("t1 enh_pulses", enh_cnt - s_enh, 0);

      // 2: two-byte instruction, pc_load with start in IDLE
      mem[0] = 8'h41; mem[1] = 8'h5A;
      s_enh = enh_cnt;
      push_exp(8'h41, 16'h005A, 16'h0002, 6);
      fetch_one("t2", 1'b1, 16'h0000);
      chk("t2 enh_pulses", enh_cnt - s_enh, 0);

      // 3: three-byte instruction, high byte first
      mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'h34;
      s_mar = mar_cnt;
      push_exp(8'h80, 16'h1234, 16'h0003, 8);
      fetch_one("t3", 1'b1, 16'h0000);
      chk("t3 mar_pulses", mar_cnt - s_mar, 3);
      chk("t3 bus0", {16'h0, bus_hist[s_mar[7:0]]}, 32'h0000);
      chk("t3 bus1", {16'h0, bus_hist[s_mar[7:0] + 8'd1]}, 32'h0001);
      chk("t3 bus2", {16'h0, bus_hist[s_mar[7:0] + 8'd2]}, 32'h0002);

      // 4: ack held high, back-to-back fetch, halt during second fetch
      mem[0] = 8'h00; mem[1] = 8'h00;
      push_exp(8'h00, 16'h0000, 16'h0001, 3);
      push_exp(8'h00, 16'h0000, 16'h0002, 3);
      ack = 1'b1;
      start_fetch(1'b1, 16'h0000, e0);
      wait_valid("t4a", v1);
      pop_check("t4a", v1 - e0);
      s_idle = idle_cnt;
      @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      wait_valid("t4b", v2);
      chk("t4 valid_gap", v2 - v1, 4);
      pop_check("t4b", v2 - v1 - 1);
      chk("t4 busy_drops", idle_cnt - s_idle, 0);
      @(negedge clk);
      chk("t4 halted", {30'h0, busy, instr_valid}, 32'd0);
      ack = 1'b0;

      // 5: jump on ack, then pc_load without ack is ignored
      mem[0] = 8'h00; mem[8'h10] = 8'h01;
      push_exp(8'h00, 16'h0000, 16'h0001, 3);
      start_fetch(1'b1, 16'h0000, e0);
      wait_valid("t5a", v1);
      pop_check("t5a", v1 - e0);
      ack = 1'b1; pc_load = 1'b1; pc_in = 16'h0010; halt_req = 1'b1;
      @(negedge clk);
      a0 = cyc;
      ack = 1'b0; pc_load = 1'b0; halt_req = 1'b0;
      chk("t5 jump_oe", {30'h0, bus_oe, mar_loadh}, 32'd3);
      chk("t5 jump_bus", {16'h0, bus_out}, 32'h0010);
      push_exp(8'h01, 16'h0000, 16'h0011, 3);
      wait_valid("t5b", v2);
      pop_check("t5b", v2 - a0);
      pc_load = 1'b1; pc_in = 16'h0055;
      repeat (2) @(negedge clk);
      chk("t5 pc_hold", {16'h0, pc}, 32'h0011);
      chk("t5 valid_hold", {31'h0, instr_valid}, 32'd1);
      pc_load = 1'b0; ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("t5 halted", {31'h0, busy}, 32'd0);

      // 6: reset during R_B1 of a three-byte fetch
      mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'h34;
      start_fetch(1'b1, 16'h0000, e0);
      repeat (4) @(negedge clk);
      chk("t6 in_rb1", {31'h0, ram_enh}, 32'd1);
      chk("t6 pre_instr", {24'h0, instr}, 32'h80);
      rst = 1'b1;
      #1;
      chk("t6 rst_outs", {25'h0, mar_loadh, mar_loadl, ram_enh, ram_enl, bus_oe, instr_valid, busy}, 32'd0);
      chk("t6 rst_pc", {16'h0, pc}, 32'h0000);
      chk("t6 rst_instr", {24'h0, instr}, 32'h0);
      chk("t6 rst_operand", {16'h0, operand}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6 stays_idle", {30'h0, busy, instr_valid}, 32'd0);
      chk("t6 pc_after", {16'h0, pc}, 32'h0000);

      chk("strobe_overlap", viol, 0);
      chk("sb_leftover", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
